isram_resp: RTL and testbench



---
 rtl/isram_resp_if.sv | 42 ++++
 rtl/isram_resp.sv | 174 +++++++++++++++++
 tb/tb_isram_resp.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/isram_resp_if.sv
// Instruction-SRAM responder bus: the fetch read port, the 32-bit load/store
// request/response port, and the ownership flags that tell fetch when the
// load/store side has stolen the array.
interface isram_resp_if;
    // fetch read port
    logic        isram_cs;
    logic [31:3] isram_adr;
    logic [63:0] instr_fromsram;

    // load/store port
    logic        ls_req;
    logic        ls_gnt;
    logic        ls_we;
    logic [31:2] ls_adr;
    logic [31:0] ls_wdata;
    logic [3:0]  ls_be;
    logic        ls_ack;
    logic [31:0] ls_rdata;
    logic        ls_err;

    // array ownership flags seen by fetch
    logic        lr_isram_cs;
    logic        lr_isram_cs_ff;

    // requester side: fetch unit plus memory-access stage
    modport master (
        output isram_cs, isram_adr,
        output ls_req, ls_we, ls_adr, ls_wdata, ls_be,
        input  instr_fromsram,
        input  ls_gnt, ls_ack, ls_rdata, ls_err,
        input  lr_isram_cs, lr_isram_cs_ff
    );

    // responder side: owns the array
    modport slave (
        input  isram_cs, isram_adr,
        input  ls_req, ls_we, ls_adr, ls_wdata, ls_be,
        output instr_fromsram,
        output ls_gnt, ls_ack, ls_rdata, ls_err,
        output lr_isram_cs, lr_isram_cs_ff
    );
endinterface

// File: rtl/isram_resp.sv
// Instruction-SRAM responder. Owns a 2^AW x 64-bit array, serves fetch reads
// with one-cycle latency and interleaves 32-bit load/store accesses by
// stealing the array for an ACC/RSP pair of cycles. While stolen, fetch
// requests are dropped and lr_isram_cs tells fetch to freeze and replay.
module isram_resp #(
    parameter int          AW   = 13,
    parameter logic [31:0] BASE = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        cpurst,
    isram_resp_if.slave bus
);

    // Word returned for fetches outside the array: two RISC-V NOPs.
    localparam logic [63:0] NOP_PAIR = 64'h0000_0013_0000_0013;
    // Byte span of the array; one extra bit so the compare cannot wrap.
    localparam logic [32:0] SPAN     = 33'd8 << AW;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        RSP  = 2'd2
    } state_t;

    state_t      state_reg;
    state_t      state_next;
    logic        capture;

    // Load/store request fields captured at accept.
    logic        ls_we_reg;
    logic [31:2] ls_adr_reg;
    logic [31:0] ls_wdata_reg;
    logic [3:0]  ls_be_reg;

    logic [63:0] dout_reg;
    logic        lr_ff_reg;

    logic [63:0] mem [0:(1<<AW)-1];

    // Address decode for both ports.
    logic [31:0] fetch_byte;
    logic [31:0] fetch_off;
    logic        fetch_ok;
    logic [31:0] ls_byte;
    logic [31:0] ls_off;
    logic        ls_ok;
    logic [AW-1:0] mem_idx;

    // Array port controls.
    logic        fetch_rd;
    logic        ls_rd;
    logic        ls_wr;
    logic [7:0]  wr_be;
    logic [63:0] wr_data;

    assign fetch_byte = {bus.isram_adr, 3'b000};
    assign fetch_off  = fetch_byte - BASE;
    assign fetch_ok   = (fetch_byte >= BASE) && ({1'b0, fetch_off} < SPAN);

    assign ls_byte    = {ls_adr_reg, 2'b00};
    assign ls_off     = ls_byte - BASE;
    assign ls_ok      = (ls_byte >= BASE) && ({1'b0, ls_off} < SPAN);

    // The array has a single port: load/store drives it only during ACC.
    assign mem_idx    = (state_reg == ACC) ? ls_off[AW+2:3] : fetch_off[AW+2:3];

    assign fetch_rd   = (state_reg == IDLE) && bus.isram_cs;
    assign ls_rd      = (state_reg == ACC) && !ls_we_reg && ls_ok;
    assign ls_wr      = (state_reg == ACC) &&  ls_we_reg && ls_ok;

    // Steer the 32-bit write into lane adr[2]; the other lane's enables stay low.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            assign wr_be[4*gi +: 4]    = (ls_adr_reg[2] == 1'(gi)) ? ls_be_reg : 4'b0000;
            assign wr_data[32*gi +: 32] = ls_wdata_reg;
        end
    endgenerate

    // State register.
    always_ff @(posedge clk or posedge cpurst) begin
        if (cpurst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state; a request is accepted whenever the grant is up (IDLE or RSP).
    always_comb begin
        state_next = state_reg;
        capture    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.ls_req) begin
                    capture    = 1'b1;
                    state_next = ACC;
                end
            end
            ACC: begin
                state_next = RSP;
            end
            RSP: begin
                if (bus.ls_req) begin
                    capture    = 1'b1;
                    state_next = ACC;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Capture the load/store fields at accept; reset drops a pending access.
    always_ff @(posedge clk or posedge cpurst) begin
        if (cpurst) begin
            ls_we_reg    <= 1'b0;
            ls_adr_reg   <= '0;
            ls_wdata_reg <= '0;
            ls_be_reg    <= '0;
        end else if (capture) begin
            ls_we_reg    <= bus.ls_we;
            ls_adr_reg   <= bus.ls_adr;
            ls_wdata_reg <= bus.ls_wdata;
            ls_be_reg    <= bus.ls_be;
        end
    end

    // Byte-masked array write at the edge ending ACC; contents are not reset.
    always_ff @(posedge clk) begin
        if (ls_wr) begin
            for (int b = 0; b < 8; b++) begin
                if (wr_be[b]) begin
                    mem[mem_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    // Registered read data; holds in any cycle without a read, so fetch still
    // sees its last word during the first cycle of a steal.
    always_ff @(posedge clk or posedge cpurst) begin
        if (cpurst) begin
            dout_reg <= '0;
        end else if (fetch_rd) begin
            dout_reg <= fetch_ok ? mem[mem_idx] : NOP_PAIR;
        end else if (ls_rd) begin
            dout_reg <= mem[mem_idx];
        end
    end

    // Delayed copy of the ownership flag for fetch's replay logic.
    always_ff @(posedge clk or posedge cpurst) begin
        if (cpurst) begin
            lr_ff_reg <= 1'b0;
        end else begin
            lr_ff_reg <= (state_reg != IDLE);
        end
    end

    assign bus.instr_fromsram = dout_reg;
    assign bus.ls_gnt         = (state_reg != ACC);
    assign bus.ls_ack         = (state_reg == RSP);
    assign bus.ls_err         = (state_reg == RSP) && !ls_ok;
    assign bus.ls_rdata       = ((state_reg == RSP) && !ls_we_reg && ls_ok)
                                ? (ls_adr_reg[2] ? dout_reg[63:32] : dout_reg[31:0])
                                : 32'h0000_0000;
    assign bus.lr_isram_cs    = (state_reg != IDLE);
    assign bus.lr_isram_cs_ff = lr_ff_reg;

endmodule

// File: tb/tb_isram_resp.sv
// Bench for isram_resp: directed scenarios followed by random fetch and
// load/store traffic, all checked against a byte-addressed memory model.
module tb_isram_resp;

    localparam int          AW        = 13;
    localparam int unsigned MEM_BYTES = 8 << AW;
    localparam logic [63:0] NOP_PAIR  = 64'h0000_0013_0000_0013;

    logic clk = 1'b0;
    logic cpurst;

    isram_resp_if bus ();

    isram_resp #(
        .AW   (AW),
        .BASE (32'h0000_0000)
    ) dut (
        .clk    (clk),
        .cpurst (cpurst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference memory: one entry per byte address.
    logic [7:0] ref_b [int];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] model_fetch(input logic [28:0] wadr);
        logic [31:0] ba;
        logic [63:0] r;
        ba = {wadr, 3'b000};
        if (ba >= MEM_BYTES) return NOP_PAIR;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = ref_b[int'(ba) + i];
        return r;
    endfunction

    function automatic logic [31:0] model_load(input logic [29:0] adr);
        logic [31:0] ba;
        logic [31:0] r;
        ba = {adr, 2'b00};
        if (ba >= MEM_BYTES) return 32'h0;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = ref_b[int'(ba) + i];
        return r;
    endfunction

    function automatic void model_store(input logic [29:0] adr, input logic [31:0] wd, input logic [3:0] be);
        logic [31:0] ba;
        ba = {adr, 2'b00};
        if (ba >= MEM_BYTES) return;
        for (int i = 0; i < 4; i++)
            if (be[i]) ref_b[int'(ba) + i] = wd[8*i +: 8];
    endfunction

    task automatic idle_inputs();
        bus.isram_cs  = 1'b0;
        bus.isram_adr = '0;
        bus.ls_req    = 1'b0;
        bus.ls_we     = 1'b0;
        bus.ls_adr    = '0;
        bus.ls_wdata  = '0;
        bus.ls_be     = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_instr"}, bus.instr_fromsram, 64'h0);
        check({tag, "_rdata"}, bus.ls_rdata, 32'h0);
        check({tag, "_ack"}, bus.ls_ack, 1'b0);
        check({tag, "_err"}, bus.ls_err, 1'b0);
        check({tag, "_lr"}, bus.lr_isram_cs, 1'b0);
        check({tag, "_lrff"}, bus.lr_isram_cs_ff, 1'b0);
        check({tag, "_gnt"}, bus.ls_gnt, 1'b1);
    endtask

    // One isolated load/store access from IDLE, optionally with a fetch in the
    // accept cycle. Checks grant, ACC, RSP and the return to IDLE.
    task automatic ls_op(input logic we, input logic [29:0] adr, input logic [31:0] wd,
                         input logic [3:0] be, input logic with_fetch, input logic [28:0] fadr,
                         output logic [31:0] rdata);
        logic [63:0] fexp;
        logic [31:0] rexp;
        logic [31:0] ba;
        logic        eexp;
        fexp = model_fetch(fadr);
        ba   = {adr, 2'b00};
        eexp = (ba >= MEM_BYTES);
        rexp = we ? 32'h0 : model_load(adr);
        bus.ls_req    = 1'b1;
        bus.ls_we     = we;
        bus.ls_adr    = adr;
        bus.ls_wdata  = wd;
        bus.ls_be     = be;
        bus.isram_cs  = with_fetch;
        bus.isram_adr = fadr;
        check("gnt_idle", bus.ls_gnt, 1'b1);
        tick();
        bus.ls_req   = 1'b0;
        bus.isram_cs = 1'b0;
        check("acc_lr", bus.lr_isram_cs, 1'b1);
        check("acc_gnt", bus.ls_gnt, 1'b0);
        check("acc_ack", bus.ls_ack, 1'b0);
        if (with_fetch) check("acc_fetch", bus.instr_fromsram, fexp);
        tick();
        rdata = bus.ls_rdata;
        check("rsp_ack", bus.ls_ack, 1'b1);
        check("rsp_err", bus.ls_err, eexp);
        check("rsp_rdata", bus.ls_rdata, rexp);
        check("rsp_lr", bus.lr_isram_cs, 1'b1);
        if (we) model_store(adr, wd, be);
        tick();
        check("end_lr", bus.lr_isram_cs, 1'b0);
        check("end_ack", bus.ls_ack, 1'b0);
        check("end_lrff", bus.lr_isram_cs_ff, 1'b1);
        $display("ls %s adr=%h wd=%h be=%b fetch=%0d rdata=%h err=%0d",
                 we ? "wr" : "rd", adr, wd, be, with_fetch, rdata, eexp);
    endtask

    // One fetch from IDLE; data one cycle later and held afterwards.
    task automatic fetch(input logic [28:0] a);
        logic [63:0] e;
        e = model_fetch(a);
        bus.isram_cs  = 1'b1;
        bus.isram_adr = a;
        tick();
        bus.isram_cs = 1'b0;
        check("fetch", bus.instr_fromsram, e);
        tick();
        check("fetch_hold", bus.instr_fromsram, e);
        $display("fetch adr=%h data=%h", a, bus.instr_fromsram);
    endtask

    logic [31:0] rd;
    logic        b2b_we   [3];
    logic [29:0] b2b_adr  [3];
    logic [31:0] b2b_wd   [3];
    logic [3:0]  b2b_be   [3];

    initial begin
        idle_inputs();
        cpurst = 1'b1;
        tick();
        tick();
        check_reset_outputs("rst");
        cpurst = 1'b0;
        tick();
        check_reset_outputs("post_rst");

        // Preload the low 16 words and the last in-range word.
        for (int w = 0; w < 32; w++) begin
            logic [31:0] d;
            d = (w == 10) ? 32'h3333_4444 : (w == 11) ? 32'h1111_2222 : $urandom;
            ls_op(1'b1, 30'(w), d, 4'hF, 1'b0, '0, rd);
        end
        ls_op(1'b1, 30'd16382, $urandom, 4'hF, 1'b0, '0, rd);
        ls_op(1'b1, 30'd16383, $urandom, 4'hF, 1'b0, '0, rd);

        // Fetch read of a known word.
        fetch(29'd5);
        check("tp_fetch", bus.instr_fromsram, 64'h1111_2222_3333_4444);

        // Partial write into the upper lane, then read back.
        ls_op(1'b1, 30'hB, 32'hAABB_CCDD, 4'b0110, 1'b0, '0, rd);
        ls_op(1'b0, 30'hB, 32'h0, 4'h0, 1'b0, '0, rd);
        check("tp_rd", rd, 32'h11BB_CC22);
        fetch(29'd5);
        check("tp_merge", bus.instr_fromsram, 64'h11BB_CC22_3333_4444);

        // Steal visibility: fetch word 5, load word 3 lane 0 the next cycle,
        // fetch word 7 requested during the steal and replayed after it.
        bus.isram_cs  = 1'b1;
        bus.isram_adr = 29'd5;
        tick();
        check("steal_f0", bus.instr_fromsram, model_fetch(29'd5));
        check("steal_lr0", bus.lr_isram_cs, 1'b0);
        bus.isram_cs = 1'b0;
        bus.ls_req   = 1'b1;
        bus.ls_we    = 1'b0;
        bus.ls_adr   = 30'd6;
        tick();
        check("steal_lr1", bus.lr_isram_cs, 1'b1);
        check("steal_hold", bus.instr_fromsram, model_fetch(29'd5));
        bus.ls_req    = 1'b0;
        bus.isram_cs  = 1'b1;
        bus.isram_adr = 29'd7;
        tick();
        check("steal_lr2", bus.lr_isram_cs, 1'b1);
        check("steal_land", bus.instr_fromsram, model_fetch(29'd3));
        check("steal_ack", bus.ls_ack, 1'b1);
        check("steal_rdata", bus.ls_rdata, model_load(30'd6));
        tick();
        check("steal_lr3", bus.lr_isram_cs, 1'b0);
        check("steal_lrff", bus.lr_isram_cs_ff, 1'b1);
        check("steal_drop", bus.instr_fromsram, model_fetch(29'd3));
        tick();
        bus.isram_cs = 1'b0;
        check("steal_replay", bus.instr_fromsram, model_fetch(29'd7));
        check("steal_lrff_end", bus.lr_isram_cs_ff, 1'b0);
        $display("steal sequence done");

        // Back-to-back: write word 20, read it back, read word 9.
        b2b_we[0] = 1'b1; b2b_adr[0] = 30'd20; b2b_wd[0] = $urandom; b2b_be[0] = 4'b1001;
        b2b_we[1] = 1'b0; b2b_adr[1] = 30'd20; b2b_wd[1] = 32'h0;    b2b_be[1] = 4'h0;
        b2b_we[2] = 1'b0; b2b_adr[2] = 30'd9;  b2b_wd[2] = 32'h0;    b2b_be[2] = 4'h0;
        bus.ls_req   = 1'b1;
        bus.ls_we    = b2b_we[0];
        bus.ls_adr   = b2b_adr[0];
        bus.ls_wdata = b2b_wd[0];
        bus.ls_be    = b2b_be[0];
        tick();
        for (int c = 1; c <= 8; c++) begin
            check("b2b_ack", bus.ls_ack, (c == 2 || c == 4 || c == 6));
            check("b2b_lr", bus.lr_isram_cs, (c <= 6));
            check("b2b_lrff", bus.lr_isram_cs_ff, (c >= 2 && c <= 7));
            if (c == 2 || c == 4 || c == 6) begin
                int k;
                k = c / 2 - 1;
                check("b2b_rdata", bus.ls_rdata, b2b_we[k] ? 32'h0 : model_load(b2b_adr[k]));
                if (b2b_we[k]) model_store(b2b_adr[k], b2b_wd[k], b2b_be[k]);
                $display("b2b op=%0d adr=%h rdata=%h", k, b2b_adr[k], bus.ls_rdata);
                if (k < 2) begin
                    bus.ls_we    = b2b_we[k+1];
                    bus.ls_adr   = b2b_adr[k+1];
                    bus.ls_wdata = b2b_wd[k+1];
                    bus.ls_be    = b2b_be[k+1];
                end else begin
                    bus.ls_req = 1'b0;
                end
            end
            tick();
        end
        idle_inputs();
        fetch(29'd10);

        // Range boundaries.
        fetch(29'd8191);
        fetch(29'h2000);
        check("oor_fetch", bus.instr_fromsram, NOP_PAIR);
        ls_op(1'b0, 30'h4000, 32'h0, 4'h0, 1'b0, '0, rd);
        ls_op(1'b1, 30'h4000, 32'hFFFF_FFFF, 4'hF, 1'b0, '0, rd);
        fetch(29'd0);

        // Reset in the ACC cycle of a write: nothing commits, outputs clear.
        bus.ls_req   = 1'b1;
        bus.ls_we    = 1'b1;
        bus.ls_adr   = 30'd4;
        bus.ls_wdata = 32'hDEAD_BEEF;
        bus.ls_be    = 4'hF;
        tick();
        bus.ls_req = 1'b0;
        #2;
        cpurst = 1'b1;
        #1;
        check_reset_outputs("rst_acc");
        tick();
        check_reset_outputs("rst_hold");
        cpurst = 1'b0;
        tick();
        check("rst_noack", bus.ls_ack, 1'b0);
        idle_inputs();
        ls_op(1'b0, 30'd4, 32'h0, 4'h0, 1'b0, '0, rd);
        $display("reset-in-acc word4=%h", rd);

        // Random traffic.
        for (int n = 0; n < 300; n++) begin
            int sel;
            sel = $urandom_range(0, 3);
            if (sel == 0) begin
                fetch(($urandom_range(0, 9) == 0) ? 29'(32'h2000 + $urandom_range(0, 100))
                                                  : 29'($urandom_range(0, 15)));
            end else if (sel == 3) begin
                tick();
            end else begin
                logic [29:0] a;
                a = ($urandom_range(0, 9) == 0) ? 30'(32'h4000 + $urandom_range(0, 200))
                                                : 30'($urandom_range(0, 31));
                ls_op(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
                      1'($urandom_range(0, 1)), 29'($urandom_range(0, 15)), rd);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
